// File: rtl/pipe_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_flow_ctrl
// Purpose  : Issue/flow controller for the 16-bit CPU: RAW scoreboard, flush
//            sequencer and EXEC state machine. Optional: PFC_R15_GUARD_EN.
// Revision : 1.0
// ============================================================================
module pipe_flow_ctrl #(
    parameter int IW          = 16,
    parameter int RA_W        = 4,
    parameter int WB_DEPTH    = 3,
    parameter int FLUSH_SLOTS = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] instr_in,
    input  logic [2:0]    flag,
    output logic          issue_valid,
    output logic          write_en,
    output logic          mem_en,
    output logic          stall,
    output logic          flush,
    output logic [1:0]    pc_sel,
    output logic          pc_hold,
    output logic [1:0]    state
);

    localparam int CNT_W = 2;

    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_LHB  = 4'hA;
    localparam logic [3:0] OP_LLB  = 4'hB;
    localparam logic [3:0] OP_B    = 4'hC;
    localparam logic [3:0] OP_JAL  = 4'hD;
    localparam logic [3:0] OP_JR   = 4'hE;
    localparam logic [3:0] OP_EXEC = 4'hF;

    localparam logic [RA_W-1:0] C_R15 = {RA_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_FLUSH    = 2'b01,
        ST_EXEC_TGT = 2'b10,
        ST_EXEC_RET = 2'b11
    } state_t;

    typedef enum logic [2:0] {
        PD_NONE = 3'd0,
        PD_BR   = 3'd1,
        PD_JAL  = 3'd2,
        PD_JR   = 3'd3,
        PD_EXEC = 3'd4
    } pend_t;

    state_t            state_q, state_d;
    pend_t             pend_q, pend_d;
    logic [2:0]        cond_q, cond_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WB_DEPTH-1:0] sb_v_q;
    logic [RA_W-1:0]   sb_rd_q [WB_DEPTH];

    logic [3:0]        w_op;
    logic [RA_W-1:0]   w_rd, w_rs, w_rt, w_dest;
    logic              w_use_rs, w_use_rt, w_use_rd, w_writer, w_we_ok;
    logic              w_hit, w_taken, w_redirect, w_chk, w_can_issue, w_hold;
    logic              w_flush, w_stall, w_issue;
    logic [1:0]        w_pc_sel;

    assign w_op = instr_in[IW-1 -: 4];
    assign w_rd = instr_in[IW-5 -: RA_W];
    assign w_rs = instr_in[IW-9 -: RA_W];
    assign w_rt = instr_in[IW-13 -: RA_W];

    always_comb begin
        w_use_rs = 1'b0;
        w_use_rt = 1'b0;
        w_use_rd = 1'b0;
        w_writer = 1'b0;
        w_dest   = w_rd;
        if (w_op <= 4'h3) begin
            w_use_rs = 1'b1;
            w_use_rt = 1'b1;
            w_writer = 1'b1;
        end else if (w_op <= OP_LW) begin
            w_use_rs = 1'b1;
            w_writer = 1'b1;
        end else begin
            case (w_op)
                OP_SW:   begin w_use_rs = 1'b1; w_use_rd = 1'b1; end
                OP_LHB:  begin w_use_rd = 1'b1; w_writer = 1'b1; end
                OP_LLB:  w_writer = 1'b1;
                OP_JAL:  begin w_writer = 1'b1; w_dest = C_R15; end
                OP_JR:   w_use_rs = 1'b1;
                OP_EXEC: w_use_rs = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef PFC_R15_GUARD_EN
    assign w_we_ok = w_writer & ~((w_rd == C_R15) & (w_op != OP_JAL));
`else
    assign w_we_ok = w_writer;
`endif

    // R0 entries are architecturally harmless, so they never raise a hazard.
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (sb_v_q[i] && (sb_rd_q[i] != '0)) begin
                if ((w_use_rs && (w_rs == sb_rd_q[i])) ||
                    (w_use_rt && (w_rt == sb_rd_q[i])) ||
                    (w_use_rd && (w_rd == sb_rd_q[i])))
                    w_hit = 1'b1;
            end
        end
    end

    always_comb begin
        case (cond_q)
            3'b000:  w_taken = ~flag[2];
            3'b001:  w_taken = flag[2];
            3'b010:  w_taken = ~flag[2] & ~flag[0];
            3'b011:  w_taken = flag[0];
            3'b100:  w_taken = flag[2] | ~flag[0];
            3'b101:  w_taken = flag[0] | flag[2];
            3'b110:  w_taken = flag[1];
            default: w_taken = 1'b1;
        endcase
    end

    always_comb begin
        w_redirect  = 1'b0;
        w_pc_sel    = 2'b00;
        w_flush     = 1'b0;
        w_chk       = 1'b0;
        w_can_issue = 1'b0;
        w_hold      = 1'b0;
        if (state_q == ST_RUN) begin
            case (pend_q)
                PD_BR:   begin w_redirect = w_taken; w_pc_sel = w_taken ? 2'b01 : 2'b00; end
                PD_JAL:  begin w_redirect = 1'b1; w_pc_sel = 2'b01; end
                PD_JR:   begin w_redirect = 1'b1; w_pc_sel = 2'b10; end
                PD_EXEC: begin w_redirect = 1'b1; w_pc_sel = 2'b11; end
                default: ;
            endcase
        end
        case (state_q)
            ST_RUN: begin
                w_flush     = w_redirect;
                w_chk       = ~w_redirect;
                w_can_issue = ~w_redirect;
            end
            ST_EXEC_TGT: begin
                w_chk       = 1'b1;
                w_can_issue = (w_op[3:2] != 2'b11);
                w_hold      = 1'b1;
            end
            default: w_flush = 1'b1;
        endcase
        w_stall = w_chk & w_hit;
        w_issue = w_can_issue & ~w_stall;
    end

    // Outputs are forced low while reset is asserted, not just after the edge.
    assign issue_valid = rst_n & w_issue;
    assign write_en    = issue_valid & w_we_ok;
    assign mem_en      = issue_valid & (w_op == OP_SW);
    assign stall       = rst_n & w_stall;
    assign flush       = rst_n & w_flush;
    assign pc_sel      = rst_n ? w_pc_sel : 2'b00;
    assign pc_hold     = rst_n & (w_stall | w_hold);
    assign state       = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = PD_NONE;
        cond_d  = cond_q;
        case (state_q)
            ST_RUN: begin
                if (w_redirect) begin
                    if (pend_q == PD_EXEC) begin
                        state_d = ST_EXEC_TGT;
                    end else if (FLUSH_SLOTS > 1) begin
                        state_d = ST_FLUSH;
                        cnt_d   = CNT_W'(FLUSH_SLOTS > 1 ? FLUSH_SLOTS - 2 : 0);
                    end
                end else if (issue_valid) begin
                    case (w_op)
                        OP_B:    begin pend_d = PD_BR; cond_d = w_rd[3:1]; end
                        OP_JAL:  pend_d = PD_JAL;
                        OP_JR:   pend_d = PD_JR;
                        OP_EXEC: pend_d = PD_EXEC;
                        default: ;
                    endcase
                end
            end
            ST_FLUSH: begin
                if (cnt_q == '0) state_d = ST_RUN;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_EXEC_TGT: if (!w_stall) state_d = ST_EXEC_RET;
            default:     state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pend_q  <= PD_NONE;
            cond_q  <= 3'b000;
            cnt_q   <= '0;
            sb_v_q  <= '0;
            for (int i = 0; i < WB_DEPTH; i++) sb_rd_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cond_q  <= cond_d;
            cnt_q   <= cnt_d;
            for (int i = WB_DEPTH - 1; i > 0; i--) begin
                sb_v_q[i]  <= sb_v_q[i-1];
                sb_rd_q[i] <= sb_rd_q[i-1];
            end
            sb_v_q[0]  <= issue_valid & write_en;
            sb_rd_q[0] <= w_dest;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_flow_ctrl
// Purpose  : Directed vector bench for pipe_flow_ctrl (WB_DEPTH=3, FLUSH_SLOTS=3
//            main instance, default-parameter side instance).
// Revision : 1.0
// ============================================================================
module tb_pipe_flow_ctrl;

    // Expected bundle: {issue, we, mem, stall, flush, pc_sel[1:0], pc_hold, state[1:0]}
    localparam logic [9:0] RST     = 10'b0_0_0_0_0_00_0_00;
    localparam logic [9:0] ISW     = 10'b1_1_0_0_0_00_0_00;
    localparam logic [9:0] ISN     = 10'b1_0_0_0_0_00_0_00;
    localparam logic [9:0] STL     = 10'b0_0_0_1_0_00_1_00;
    localparam logic [9:0] SWV     = 10'b1_0_1_0_0_00_0_00;
    localparam logic [9:0] F01     = 10'b0_0_0_0_1_01_0_00;
    localparam logic [9:0] F10     = 10'b0_0_0_0_1_10_0_00;
    localparam logic [9:0] F11     = 10'b0_0_0_0_1_11_0_00;
    localparam logic [9:0] FLS     = 10'b0_0_0_0_1_00_0_01;
    localparam logic [9:0] TGT_SQ  = 10'b0_0_0_0_0_00_1_10;
    localparam logic [9:0] TGT_STL = 10'b0_0_0_1_0_00_1_10;
    localparam logic [9:0] TGT_ISW = 10'b1_1_0_0_0_00_1_10;
    localparam logic [9:0] RET     = 10'b0_0_0_0_1_00_0_11;
`ifdef PFC_R15_GUARD_EN
    localparam logic [9:0] R15W    = ISN;
`else
    localparam logic [9:0] R15W    = ISW;
`endif

    typedef struct {
        logic        rst_n;
        logic [15:0] instr;
        logic [2:0]  flag;
        logic [9:0]  exp;
        logic        chk1;
        logic [2:0]  exp1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] instr_in = 16'h0000;
    logic [2:0]  flag = 3'b000;

    logic        iv, we, me, st, fl, ph;
    logic [1:0]  ps, sta;
    logic        iv1, we1, me1, st1, fl1, ph1;
    logic [1:0]  ps1, sta1;

    int n_vec = 0;
    int n_err = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    pipe_flow_ctrl #(.IW(16), .RA_W(4), .WB_DEPTH(3), .FLUSH_SLOTS(3)) dut (
        .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .flag(flag),
        .issue_valid(iv), .write_en(we), .mem_en(me), .stall(st), .flush(fl),
        .pc_sel(ps), .pc_hold(ph), .state(sta)
    );

    pipe_flow_ctrl dut1 (
        .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .flag(flag),
        .issue_valid(iv1), .write_en(we1), .mem_en(me1), .stall(st1), .flush(fl1),
        .pc_sel(ps1), .pc_hold(ph1), .state(sta1)
    );

    task automatic add(input logic r, input logic [15:0] ins, input logic [2:0] f,
                       input logic [9:0] e);
        vec_t v;
        v.rst_n = r; v.instr = ins; v.flag = f; v.exp = e; v.chk1 = 1'b0; v.exp1 = 3'b000;
        vecs.push_back(v);
    endtask

    // Side-instance expectation: {flush, state}
    task automatic add1(input logic [15:0] ins, input logic [2:0] f, input logic [9:0] e,
                        input logic [2:0] e1);
        vec_t v;
        v.rst_n = 1'b1; v.instr = ins; v.flag = f; v.exp = e; v.chk1 = 1'b1; v.exp1 = e1;
        vecs.push_back(v);
    endtask

    task automatic step(input string name, input vec_t v);
        logic [9:0] got;
        logic [2:0] got1;
        @(negedge clk);
        rst_n    = v.rst_n;
        instr_in = v.instr;
        flag     = v.flag;
        #1;
        got = {iv, we, me, st, fl, ps, ph, sta};
        n_vec++;
        if (got !== v.exp) begin
            n_err++;
            $display("FAIL %s instr=%h got=%b required=%b", name, v.instr, got, v.exp);
        end
        if (v.chk1) begin
            got1 = {fl1, sta1};
            n_vec++;
            if (got1 !== v.exp1) begin
                n_err++;
                $display("FAIL %s_slots1 instr=%h got=%b required=%b", name, v.instr, got1, v.exp1);
            end
        end
    endtask

    task automatic hand(input string name, input logic r, input logic [15:0] ins,
                        input logic [2:0] f, input logic [9:0] e);
        vec_t v;
        v.rst_n = r; v.instr = ins; v.flag = f; v.exp = e; v.chk1 = 1'b0; v.exp1 = 3'b000;
        step(name, v);
    endtask

    initial begin
        // Reset, RAW stall on ADD->ADD, SW, LHB reads rd, LLB/shift/R0 non-hazards
        add(0, 16'h0123, 3'b000, RST);
        add(1, 16'h0123, 3'b000, ISW);
        add(1, 16'h0411, 3'b000, STL);
        add(1, 16'h0411, 3'b000, STL);
        add(1, 16'h0411, 3'b000, STL);
        add(1, 16'h0411, 3'b000, ISW);
        add(1, 16'h9780, 3'b000, SWV);
        add(1, 16'hA400, 3'b000, STL);
        add(1, 16'hA400, 3'b000, STL);
        add(1, 16'hA400, 3'b000, ISW);
        add(1, 16'hB400, 3'b000, ISW);
        add(1, 16'h5564, 3'b000, ISW);
        add(1, 16'h0012, 3'b000, ISW);
        add(1, 16'h0300, 3'b000, ISW);
        // SUB, B EQ taken with hazard pending in ID: flush wins, 3 flush cycles
        add(1, 16'h1912, 3'b000, ISW);
        add(1, 16'hC200, 3'b000, ISN);
        add1(16'h0199, 3'b100, F01, 3'b1_00);
        add1(16'h0199, 3'b100, FLS, 3'b0_00);
        add(1, 16'h0199, 3'b000, FLS);
        add(1, 16'h0199, 3'b000, ISW);
        // NE not taken, GT taken, OF not taken, LE taken
        add(1, 16'hC000, 3'b000, ISN);
        add(1, 16'h0233, 3'b100, ISW);
        add(1, 16'hC400, 3'b000, ISN);
        add(1, 16'h0000, 3'b000, F01);
        add(1, 16'h0000, 3'b000, FLS);
        add(1, 16'h0000, 3'b000, FLS);
        add(1, 16'hCC00, 3'b000, ISN);
        add(1, 16'h0000, 3'b000, ISW);
        add(1, 16'hCA00, 3'b000, ISN);
        add(1, 16'h0000, 3'b001, F01);
        add(1, 16'h0000, 3'b000, FLS);
        add(1, 16'h0000, 3'b000, FLS);
        // LW R5 then JR R5, then JAL
        add(1, 16'h8560, 3'b000, ISW);
        add(1, 16'hE050, 3'b000, STL);
        add(1, 16'hE050, 3'b000, STL);
        add(1, 16'hE050, 3'b000, STL);
        add(1, 16'hE050, 3'b000, ISN);
        add(1, 16'h0000, 3'b000, F10);
        add(1, 16'h0000, 3'b000, FLS);
        add(1, 16'h0000, 3'b000, FLS);
        add(1, 16'hD000, 3'b000, ISW);
        add(1, 16'h0000, 3'b000, F01);
        add(1, 16'h0000, 3'b000, FLS);
        add(1, 16'h0000, 3'b000, FLS);
        // EXEC with branch target (squashed, no pending redirect afterwards)
        add(1, 16'hF060, 3'b000, ISN);
        add(1, 16'h0000, 3'b000, F11);
        add(1, 16'hC200, 3'b000, TGT_SQ);
        add(1, 16'h0000, 3'b000, RET);
        add(1, 16'h0000, 3'b000, ISW);
        // EXEC whose target stalls on R7 once
        add(1, 16'h0712, 3'b000, ISW);
        add(1, 16'hF080, 3'b000, ISN);
        add(1, 16'h0000, 3'b000, F11);
        add(1, 16'h0377, 3'b000, TGT_STL);
        add(1, 16'h0377, 3'b000, TGT_ISW);
        add(1, 16'h0000, 3'b000, RET);
        // Non-JAL write to R15
        add(1, 16'h0F12, 3'b000, R15W);
        // Reset while in EXEC_TGT
        add(1, 16'hF060, 3'b000, ISN);
        add(1, 16'h0000, 3'b000, F11);
        add(1, 16'h0000, 3'b000, TGT_ISW);
        add(0, 16'h0000, 3'b000, RST);
        add(1, 16'h0000, 3'b000, ISW);
        add(1, 16'h0000, 3'b000, ISW);

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset in the middle of a flush sequence: no leftover flush afterwards
        hand("mf_b_always", 1, 16'hCE00, 3'b000, ISN);
        hand("mf_taken",    1, 16'h0000, 3'b000, F01);
        hand("mf_flush",    1, 16'h0000, 3'b000, FLS);
        hand("mf_reset",    0, 16'h0000, 3'b000, RST);
        hand("mf_release",  1, 16'h0000, 3'b000, ISW);
        hand("mf_run",      1, 16'h0000, 3'b000, ISW);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
